md_sched: RTL and testbench

//  Multi-cycle multiply/divide scheduler for the E stage of the pipelined MIPS core.

---
 rtl/md_sched.sv | 133 +++++++++++++
 tb/tb_md_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler for the E stage: latches the HI/LO result at issue
// and commits it to the architectural HI/LO registers after the configured latency.
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               done_q;
   logic [31:0]        hi_q;
   logic [31:0]        lo_q;
   logic [31:0]        pend_hi_q;
   logic [31:0]        pend_lo_q;
   logic [63:0]        res_d;
   logic               accept_md;

   // Returns {hi, lo} for ops 0..3; divide-by-zero and the signed overflow case are explicit.
   function automatic logic [63:0] md_result(input logic [2:0] f_op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic signed [63:0] sp;
      logic [31:0]        q;
      logic [31:0]        r;
      sa = $signed(a);
      sb = $signed(b);
      md_result = 64'd0;
      case (f_op)
         3'd0: begin
            sp = sa * sb;
            md_result = sp;
         end
         3'd1: md_result = {32'd0, a} * {32'd0, b};
         3'd2: begin
            if (b == 32'd0) begin
               md_result = {a, 32'hFFFF_FFFF};
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               md_result = {32'd0, 32'h8000_0000};
            end else begin
               q = sa / sb;
               r = sa % sb;
               md_result = {r, q};
            end
         end
         3'd3: begin
            if (b == 32'd0) md_result = {a, 32'hFFFF_FFFF};
            else            md_result = {a % b, a / b};
         end
         default: md_result = 64'd0;
      endcase
   endfunction

   assign res_d     = md_result(op, rs, rt);
   assign accept_md = (state_q == IDLE) && start && (op[2] == 1'b0);

   // Pending result is pure data: captured at issue, only observable after commit.
   always_ff @(posedge clk) begin
      if (accept_md) begin
         pend_hi_q <= res_d[63:32];
         pend_lo_q <= res_d[31:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  case (op)
                     3'd0, 3'd1: begin
                        cnt_q   <= CNT_W'(MULT_CYCLES - 1);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                     end
                     3'd2, 3'd3: begin
                        cnt_q   <= CNT_W'(DIV_CYCLES - 1);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                     end
                     3'd4:    hi_q <= rs;
                     3'd5:    lo_q <= rs;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               // Any start seen here is dropped; hazard logic should never issue one.
               if (cnt_q == '0) begin
                  hi_q    <= pend_hi_q;
                  lo_q    <= pend_lo_q;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: latency, arithmetic corner cases, MTHI/MTLO, ignored
// starts while busy and asynchronous reset of an in-flight divide.
module tb_md_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors     = 0;
   int miscompares = 0;

   md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .rs    (rs),
      .rt    (rt),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      rs    = a;
      rt    = b;
      tick();
      start = 1'b0;
   endtask

   // Issues a mult/div op and checks busy for exactly n cycles, then the commit cycle.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] old_hi, input logic [31:0] old_lo,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      issue(o, a, b);
      for (int i = 0; i < n; i++) begin
         chk({tag, " busy"}, 32'(busy), 32'd1);
         chk({tag, " done low"}, 32'(done), 32'd0);
         chk({tag, " hi hold"}, hi, old_hi);
         chk({tag, " lo hold"}, lo, old_lo);
         tick();
      end
      chk({tag, " busy cleared"}, 32'(busy), 32'd0);
      chk({tag, " done pulse"}, 32'(done), 32'd1);
      chk({tag, " hi"}, hi, exp_hi);
      chk({tag, " lo"}, lo, exp_lo);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      rs    = 32'd0;
      rt    = 32'd0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);

      run_op("mult 3*-4", 3'd0, 32'd3, 32'hFFFF_FFFC, 5,
             32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
      tick();
      chk("mult done one cycle", 32'(done), 32'd0);

      run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5,
             32'hFFFF_FFFF, 32'hFFFF_FFF4, 32'h0000_0001, 32'hFFFF_FFFE);
      tick();
      run_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 10,
             32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      tick();
      run_op("div 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE, 10,
             32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'hFFFF_FFFD);
      tick();
      run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10,
             32'h0000_0001, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);
      tick();
      run_op("divu 7/0", 3'd3, 32'd7, 32'd0, 10,
             32'h0000_0000, 32'h8000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
      tick();

      issue(3'd5, 32'h0000_00AA, 32'd0);
      chk("mtlo lo", lo, 32'h0000_00AA);
      chk("mtlo hi kept", hi, 32'h0000_0007);
      chk("mtlo busy", 32'(busy), 32'd0);
      chk("mtlo done", 32'(done), 32'd0);
      issue(3'd4, 32'h0000_1234, 32'd0);
      chk("mthi hi", hi, 32'h0000_1234);
      chk("mthi lo kept", lo, 32'h0000_00AA);
      issue(3'd6, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      chk("rsvd hi", hi, 32'h0000_1234);
      chk("rsvd lo", lo, 32'h0000_00AA);
      chk("rsvd busy", 32'(busy), 32'd0);
      tick();
      chk("rsvd late busy", 32'(busy), 32'd0);

      run_op("mult 6*7", 3'd0, 32'd6, 32'd7, 5,
             32'h0000_1234, 32'h0000_00AA, 32'h0000_0000, 32'h0000_002A);
      run_op("mult on done", 3'd0, 32'hFFFF_FFFE, 32'd5, 5,
             32'h0000_0000, 32'h0000_002A, 32'hFFFF_FFFF, 32'hFFFF_FFF6);
      tick();
      chk("b2b done low", 32'(done), 32'd0);

      issue(3'd0, 32'd2, 32'd2);
      tick();
      start = 1'b1;
      op    = 3'd4;
      rs    = 32'h0000_0055;
      tick();
      start = 1'b0;
      chk("busy mthi ignored hi", hi, 32'hFFFF_FFFF);
      chk("busy mthi busy", 32'(busy), 32'd1);
      tick();
      tick();
      chk("busy mthi still busy", 32'(busy), 32'd1);
      tick();
      chk("busy mthi done", 32'(done), 32'd1);
      chk("busy mthi final hi", hi, 32'h0000_0000);
      chk("busy mthi final lo", lo, 32'h0000_0004);
      tick();

      issue(3'd2, 32'd100, 32'd7);
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst hi", hi, 32'd0);
      chk("rst lo", lo, 32'd0);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("rst no commit done", 32'(done), 32'd0);
      end
      chk("rst no commit busy", 32'(busy), 32'd0);
      chk("rst no commit hi", hi, 32'd0);
      chk("rst no commit lo", lo, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
